// File: rtl/prog_loader.sv
// Boot-time program loader: receives a length-prefixed word stream from a byte
// receiver and writes it into instruction memory. Optional checksum: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic [15:0] waddr,
  output logic [15:0] wdata,
  output logic        we,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
`ifdef PROG_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CSUM;
  logic [7:0] csum;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t            state, state_nx;
  logic [7:0]        hi_byte;
  logic [15:0]       word_len;
  logic [15:0]       word_cnt;
  logic [TMR_W-1:0]  timer;
  logic [15:0]       len_c;
  logic              loading, loading_nx, accept, timed_out, last_word;

  assign loading   = !(state == IDLE || state == DONE || state == ERROR);
  assign accept    = loading && rx_valid;
  assign timed_out = loading && !rx_valid && (timer == TMR_W'(TIMEOUT - 1));
  assign last_word = ((word_cnt + 16'd1) == word_len);
  assign len_c     = {hi_byte, rx_byte};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic: one state step per accepted byte, timeout overrides
  always_comb begin
    state_nx   = state;
    loading_nx = 1'b0;
    case (state)
      IDLE, DONE, ERROR: if (start) state_nx = LEN_HI;
      LEN_HI:  if (accept) state_nx = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (len_c > 16'(DEPTH))  state_nx = ERROR;
          else if (len_c == 16'd0) state_nx = AFTER_DATA;
          else                     state_nx = DATA_HI;
        end
      end
      DATA_HI: if (accept) state_nx = DATA_LO;
      DATA_LO: if (accept) state_nx = last_word ? AFTER_DATA : DATA_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM:    if (accept) state_nx = (rx_byte == csum) ? DONE : ERROR;
`endif
      default: state_nx = IDLE;
    endcase
    if (timed_out) state_nx = ERROR;
    loading_nx = !(state_nx == IDLE || state_nx == DONE || state_nx == ERROR);
  end

  // Datapath, byte timer and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waddr     <= 16'd0;
      wdata     <= 16'd0;
      we        <= 1'b0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      hi_byte   <= 8'd0;
      word_len  <= 16'd0;
      word_cnt  <= 16'd0;
      timer     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum      <= 8'd0;
`endif
    end else begin
      we        <= 1'b0;
      cpu_hold  <= loading_nx;
      load_done <= (state_nx == DONE);
      load_err  <= (state_nx == ERROR);
      if (!loading) begin
        if (start) begin
          word_cnt <= 16'd0;
          timer    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum     <= 8'd0;
`endif
        end
      end else if (accept) begin
        timer <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        if (state != CSUM) csum <= csum + rx_byte;
`endif
        case (state)
          LEN_HI:  hi_byte  <= rx_byte;
          LEN_LO:  word_len <= len_c;
          DATA_HI: hi_byte  <= rx_byte;
          DATA_LO: begin
            we       <= 1'b1;
            waddr    <= word_cnt;
            wdata    <= len_c;
            word_cnt <= word_cnt + 16'd1;
          end
          default: ;
        endcase
      end else begin
        timer <= timer + TMR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a stream-level reference model.
module tb_prog_loader;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic [15:0] waddr, wdata;
  logic        we, cpu_hold, load_done, load_err;

  prog_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .waddr(waddr), .wdata(wdata), .we(we), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  stream[$];
  logic [31:0] exp_wr[$];
  logic [31:0] got_wr[$];
  logic        exp_done, exp_err, exp_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every write strobe observed is captured as {addr, data}
  always @(negedge clk) if (we) got_wr.push_back({waddr, wdata});

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_start);
    rx_valid = 1'b1;
    rx_byte  = b;
    start    = with_start;
    tick(1);
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Reference: interpret the byte stream as the loader format and predict the outcome
  task automatic model();
    int         n, pos;
    logic [7:0] sum;
    exp_wr.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_to = 1'b0;
    if (stream.size() < 2) begin exp_err = 1'b1; exp_to = 1'b1; return; end
    n   = int'({stream[0], stream[1]});
    sum = stream[0] + stream[1];
    if (n > int'(DEPTH)) begin exp_err = 1'b1; return; end
    pos = 2;
    for (int k = 0; k < n; k++) begin
      if (pos + 1 >= stream.size()) begin exp_err = 1'b1; exp_to = 1'b1; return; end
      exp_wr.push_back({16'(k), stream[pos], stream[pos+1]});
      sum = sum + stream[pos] + stream[pos+1];
      pos += 2;
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (pos >= stream.size()) begin exp_err = 1'b1; exp_to = 1'b1; return; end
    if (stream[pos] == sum) exp_done = 1'b1;
    else                    exp_err  = 1'b1;
`else
    exp_done = 1'b1;
`endif
  endtask

  task automatic build(input int n, input bit bad_csum, input int keep);
    logic [7:0] sum, b;
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    sum = stream[0] + stream[1];
    if (n <= int'(DEPTH)) begin
      for (int i = 0; i < 2 * n; i++) begin
        b = 8'($urandom);
        stream.push_back(b);
        sum = sum + b;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      stream.push_back(bad_csum ? sum + 8'd1 : sum);
`endif
    end
    if (keep >= 0) begin
      while (stream.size() > keep) void'(stream.pop_back());
    end else begin
      // trailing bytes land in DONE/ERROR and must be ignored
      stream.push_back(8'($urandom));
      stream.push_back(8'($urandom));
    end
  endtask

  task automatic run_load(input string tag, input int max_gap);
    model();
    got_wr.delete();
    do_start();
    check({tag, "_hold_on"}, 32'(cpu_hold), 32'd1);
    foreach (stream[i]) begin
      tick($urandom_range(0, max_gap));
      send_byte(stream[i], 1'b0);
    end
    tick(exp_to ? int'(TIMEOUT) + 2 : 3);
    check({tag, "_nwr"}, 32'(got_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      check({tag, "_wr"}, got_wr[i], exp_wr[i]);
    check({tag, "_done"}, 32'(load_done), 32'(exp_done));
    check({tag, "_err"},  32'(load_err),  32'(exp_err));
    check({tag, "_hold_off"}, 32'(cpu_hold), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_waddr"}, 32'(waddr), 32'd0);
    check({tag, "_wdata"}, 32'(wdata), 32'd0);
    check({tag, "_we"},    32'(we),    32'd0);
    check({tag, "_hold"},  32'(cpu_hold), 32'd0);
    check({tag, "_done"},  32'(load_done), 32'd0);
    check({tag, "_err"},   32'(load_err),  32'd0);
  endtask

  initial begin
    int n, keep, full;
    bit bad;
    #1;
    check_all_zero("rst");
    tick(3);
    rst = 1'b1;
    tick(2);

    // Two-word reference load with constant expectations
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef PROG_LOADER_CHECKSUM_EN
    stream.push_back(8'hC0);
`endif
    run_load("two_words", 2);
    check("two_w0", got_wr.size() > 0 ? got_wr[0] : 32'hDEAD, 32'h0000_1234);
    check("two_w1", got_wr.size() > 1 ? got_wr[1] : 32'hDEAD, 32'h0001_ABCD);
    check("two_done_k", 32'(load_done), 32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
    run_load("bad_csum", 2);
    check("bad_err_k", 32'(load_err), 32'd1);
`endif

    stream = '{8'h04, 8'h01, 8'h11, 8'h22};
    run_load("len_big", 1);
    check("len_big_nwr_k", 32'(got_wr.size()), 32'd0);
    build(DEPTH + 1, 1'b0, -1);
    run_load("len_depth_p1", 1);
    build(DEPTH, 1'b0, -1);
    run_load("len_depth", 1);

    // Timeout exactly TIMEOUT idle cycles after the last accepted byte
    got_wr.delete();
    do_start();
    send_byte(8'h00, 1'b0); send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    tick(TIMEOUT - 1);
    check("to_early", 32'(load_err), 32'd0);
    tick(1);
    check("to_err", 32'(load_err), 32'd1);
    check("to_nwr", 32'(got_wr.size()), 32'd1);
    check("to_w0", got_wr.size() > 0 ? got_wr[0] : 32'hDEAD, 32'h0000_1122);

    // Reset mid-load, then bytes without start are ignored
    do_start();
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h55, 1'b0);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    tick(1);
    rst = 1'b1;
    got_wr.delete();
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    tick(3);
    check("post_rst_nwr", 32'(got_wr.size()), 32'd0);
    check("post_rst_done", 32'(load_done), 32'd0);
    check("post_rst_hold", 32'(cpu_hold), 32'd0);

    // Empty load with start asserted alongside every byte
    got_wr.delete();
    do_start();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("empty_hold_csum", 32'(cpu_hold), 32'd1);
    send_byte(8'h00, 1'b1);
`endif
    tick(2);
    check("empty_done", 32'(load_done), 32'd1);
    check("empty_err", 32'(load_err), 32'd0);
    check("empty_nwr", 32'(got_wr.size()), 32'd0);

    // Randomized loads: lengths around the limit, bad checksums, truncations
    for (int t = 0; t < 40; t++) begin
      n    = $urandom_range(0, DEPTH + 2);
      bad  = ($urandom_range(0, 4) == 0);
      full = (n <= int'(DEPTH)) ? 2 + 2 * n : 2;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (n <= int'(DEPTH)) full += 1;
`endif
      keep = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, full - 1)) : -1;
      build(n, bad, keep);
      run_load("rand", 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
